// File: rtl/corelet_pkg.sv
// Shared types for the corelet sequencer: FSM states, inst bit positions and an inst builder.
package corelet_pkg;

  typedef enum logic [3:0] {
    IDLE, W_PRIME, W_LOAD, W_FLUSH, A_PRIME, A_EXEC, A_TAIL, A_DRAIN, DONE
  } state_t;

  localparam int L0RD  = 4;
  localparam int WR    = 3;
  localparam int MODE  = 2;
  localparam int EXEC  = 1;
  localparam int WLOAD = 0;

  function automatic logic [4:0] mk_inst(input logic l0rd, input logic wr, input logic mode,
                                         input logic exec, input logic wload);
    logic [4:0] r;
    r        = '0;
    r[L0RD]  = l0rd;
    r[WR]    = wr;
    r[MODE]  = mode;
    r[EXEC]  = exec;
    r[WLOAD] = wload;
    return r;
  endfunction

endpackage

// File: rtl/corelet_ctrl_cnt.sv
// Loadable up-counter with equality compare against a terminal value.
module corelet_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] q,
  output logic         hit
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (ld)  q <= ld_val;
    else if (inc) q <= q + 1'b1;
  end

  assign hit = (q == term);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet sequencer: weight load, flush, activation execute and psum drain.
// Define CORELET_CTRL_STALL_EN to honour data_valid and issue bubbles on missing words.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int bw        = 2,
  parameter int row       = 2,
  parameter int col       = 2,
  parameter int CNT_W     = 8,
  parameter int DRAIN_MAX = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode_4b,
  input  logic [CNT_W-1:0]      num_act,
  input  logic [row*bw*2-1:0]   data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [row*bw*2-1:0]   in,
  output logic [4:0]            inst,
  input  logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam logic [CNT_W-1:0] W_TERM = CNT_W'(row - 1);
  localparam logic [CNT_W-1:0] F_TERM = CNT_W'(row + col - 1);
  localparam logic [CNT_W-1:0] D_TERM = CNT_W'(DRAIN_MAX - 1);

  state_t           state, nxt;
  logic             m;
  logic [CNT_W-1:0] na;
  logic             acc, to_set;
  logic [4:0]       inst_nxt;

  logic             wa_ld, wa_inc, wa_hit;
  logic [CNT_W-1:0] wa_term, wcnt;
  logic             fd_ld, fd_inc, fd_hit;
  logic [CNT_W-1:0] fd_term, dcnt;
  logic             v_inc, v_hit, v_reach;
  logic [CNT_W-1:0] vcnt;
  logic             unused_cnt;

  assign data_ready = state inside {W_PRIME, W_LOAD, A_PRIME, A_EXEC};
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

`ifdef CORELET_CTRL_STALL_EN
  assign acc = data_ready & data_valid;
`else
  logic unused_dv;
  assign unused_dv = data_valid;
  assign acc       = data_ready;
`endif

  // wcnt and acnt share one counter; flush and drain share another
  assign wa_term = (state inside {W_PRIME, W_LOAD}) ? W_TERM : na - 1'b1;
  assign fd_term = (state == W_FLUSH) ? F_TERM : D_TERM;
  assign fd_ld   = !(state inside {W_FLUSH, A_DRAIN});
  assign fd_inc  = 1'b1;

  // valid pulses are counted from A_PRIME on and saturate at num_act
  assign v_inc   = valid & !v_hit & (state inside {A_PRIME, A_EXEC, A_TAIL, A_DRAIN});
  assign v_reach = v_hit | (valid & (vcnt == na - 1'b1));

  corelet_ctrl_cnt #(.W(CNT_W)) u_wa (
    .clk(clk), .reset(reset), .ld(wa_ld), .ld_val(CNT_W'(1)), .inc(wa_inc),
    .term(wa_term), .q(wcnt), .hit(wa_hit)
  );

  corelet_ctrl_cnt #(.W(CNT_W)) u_fd (
    .clk(clk), .reset(reset), .ld(fd_ld), .ld_val('0), .inc(fd_inc),
    .term(fd_term), .q(dcnt), .hit(fd_hit)
  );

  corelet_ctrl_cnt #(.W(CNT_W)) u_v (
    .clk(clk), .reset(reset), .ld(state == IDLE), .ld_val('0), .inc(v_inc),
    .term(na), .q(vcnt), .hit(v_hit)
  );

  assign unused_cnt = ^{wcnt, dcnt};

  always_comb begin
    nxt      = state;
    inst_nxt = '0;
    wa_ld    = 1'b0;
    wa_inc   = 1'b0;
    to_set   = 1'b0;
    case (state)
      IDLE: if (start) nxt = W_PRIME;
      W_PRIME: begin
        inst_nxt = mk_inst(1'b0, 1'b0, m, 1'b0, 1'b0);
        if (acc) begin
          inst_nxt = mk_inst(1'b0, 1'b1, m, 1'b0, 1'b0);
          wa_ld    = 1'b1;
          nxt      = (row == 1) ? W_FLUSH : W_LOAD;
        end
      end
      W_LOAD: begin
        inst_nxt = mk_inst(1'b0, 1'b0, m, 1'b0, 1'b0);
        if (acc) begin
          inst_nxt = mk_inst(1'b1, 1'b1, m, 1'b0, 1'b1);
          wa_inc   = 1'b1;
          if (wa_hit) nxt = W_FLUSH;
        end
      end
      W_FLUSH: begin
        inst_nxt = mk_inst(1'b1, 1'b0, m, 1'b0, 1'b1);
        if (fd_hit) nxt = (na != '0) ? A_PRIME : DONE;
      end
      A_PRIME: begin
        inst_nxt = mk_inst(1'b0, 1'b0, m, 1'b0, 1'b0);
        if (acc) begin
          inst_nxt = mk_inst(1'b0, 1'b1, m, 1'b0, 1'b0);
          wa_ld    = 1'b1;
          nxt      = (na > 1) ? A_EXEC : A_TAIL;
        end
      end
      A_EXEC: begin
        inst_nxt = mk_inst(1'b0, 1'b0, m, 1'b0, 1'b0);
        if (acc) begin
          inst_nxt = mk_inst(1'b1, 1'b1, m, 1'b1, 1'b0);
          wa_inc   = 1'b1;
          if (wa_hit) nxt = A_TAIL;
        end
      end
      A_TAIL: begin
        inst_nxt = mk_inst(1'b1, 1'b0, m, 1'b1, 1'b0);
        nxt      = A_DRAIN;
      end
      A_DRAIN: begin
        inst_nxt = mk_inst(1'b0, 1'b0, m, 1'b0, 1'b0);
        if (v_reach) nxt = DONE;
        else if (fd_hit) begin
          to_set = 1'b1;
          nxt    = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      inst    <= '0;
      in      <= '0;
      m       <= 1'b0;
      na      <= '0;
      timeout <= 1'b0;
    end else begin
      state <= nxt;
      inst  <= inst_nxt;
      if (acc) in <= data_in;
      if (state == IDLE && start) begin
        m       <= mode_4b;
        na      <= num_act;
        timeout <= 1'b0;
      end else if (to_set) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Randomized bench for corelet_ctrl against a cycle-timeline model of the sequencer.
module tb_corelet_ctrl;

  localparam int BW = 2, ROW = 2, COL = 2, CNT_W = 8, DRAIN_MAX = 64;
  localparam int DW = ROW * BW * 2;
`ifdef CORELET_CTRL_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic             clk = 1'b0, reset = 1'b1, start = 1'b0, mode_4b = 1'b0;
  logic             data_valid = 1'b0, valid = 1'b0;
  logic [CNT_W-1:0] num_act = '0;
  logic [DW-1:0]    data_in = '0;
  logic             data_ready, busy, done, timeout;
  logic [DW-1:0]    dout;
  logic [4:0]       inst;

  int            checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] exp_in = '0;
  bit            prev_to = 1'b0;

  corelet_ctrl #(.bw(BW), .row(ROW), .col(COL), .CNT_W(CNT_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_4b(mode_4b), .num_act(num_act),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready), .in(dout),
    .inst(inst), .valid(valid), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [4:0] ins(input bit l, input bit w, input bit md, input bit e, input bit wl);
    return {l, w, md, e, wl};
  endfunction

  // One full job. Valid pulses are scheduled by the bench at random distinct cycles
  // starting at A_PRIME; the expected drain length follows from the last pulse.
  task automatic run(input bit md, input int na, input bit no_valid, input bit busy_start,
                     input bit drop3);
    int t, ap, entry, d, n, bub, last, w, acc_cnt, done_cnt, busy_cnt, drop_left, tmp, j;
    bit exp_to, dropped, acc, acc_prev;
    logic [DW-1:0] word_prev;
    logic [4:0] exp_q[$], got_q[$];
    bit vmap[int];
    int pool[$];
    t = cyc;
    bub = (STALL && drop3) ? 3 : 0;
    ap = t + 1 + 2*ROW + COL;
    entry = ap + na + 1 + bub;
    last = -1;
    if (na > 0 && !no_valid) begin
      w = na + $urandom_range(0, 16);
      for (int i = 0; i < w; i++) pool.push_back(ap + i);
      for (int i = w - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = pool[i]; pool[i] = pool[j]; pool[j] = tmp;
      end
      for (int i = 0; i < na; i++) begin
        vmap[pool[i]] = 1'b1;
        if (pool[i] > last) last = pool[i];
      end
    end
    exp_to = (na > 0) && no_valid;
    d = no_valid ? DRAIN_MAX : ((last >= entry) ? last - entry + 1 : 1);
    if (d > DRAIN_MAX) begin d = DRAIN_MAX; exp_to = 1'b1; end
    n = (na > 0) ? 2*ROW + COL + na + 1 + bub + d + 1 : 2*ROW + COL + 1;

    exp_q.push_back(ins(0, 1, md, 0, 0));
    repeat (ROW - 1) exp_q.push_back(ins(1, 1, md, 0, 1));
    repeat (ROW + COL) exp_q.push_back(ins(1, 0, md, 0, 1));
    if (na > 0) begin
      exp_q.push_back(ins(0, 1, md, 0, 0));
      for (int i = 1; i < na; i++) begin
        exp_q.push_back(ins(1, 1, md, 1, 0));
        if (i == 1) repeat (bub) exp_q.push_back(ins(0, 0, md, 0, 0));
      end
      exp_q.push_back(ins(1, 0, md, 1, 0));
      repeat (d) exp_q.push_back(ins(0, 0, md, 0, 0));
    end
    exp_q.push_back(5'b0);

    if (prev_to) chk("timeout_sticky", 32'(timeout), 1);
    chk("ready_idle", 32'(data_ready), 0);
    start = 1'b1; mode_4b = md; num_act = CNT_W'(na);
    data_valid = 1'b1; data_in = DW'($urandom); valid = 1'b0;
    acc = data_ready && (data_valid || !STALL);
    acc_prev = acc; word_prev = data_in;
    if (acc) acc_cnt++;

    for (int k = 1; k <= n + 2; k++) begin
      tick();
      if (acc_prev) exp_in = word_prev;
      chk("in", 32'(dout), 32'(exp_in));
      if (k >= 2 && k <= n + 1) got_q.push_back(inst);
      if (busy) busy_cnt++;
      if (k == 1) chk("timeout_clr", 32'(timeout), 0);
      if (done) begin
        done_cnt++;
        chk("done_cyc", k, n);
        chk("timeout", 32'(timeout), 32'(exp_to));
      end
      start = busy_start && (k == ROW + 2);
      mode_4b = 1'($urandom); num_act = CNT_W'($urandom); data_in = DW'($urandom);
      if (drop3 && !dropped && acc_cnt == ROW + 2) begin drop_left = 3; dropped = 1'b1; end
      data_valid = (drop_left == 0);
      if (drop_left > 0) drop_left--;
      valid = (vmap.exists(cyc) != 0);
      acc = data_ready && (data_valid || !STALL);
      acc_prev = acc; word_prev = data_in;
      if (acc) acc_cnt++;
    end
    start = 1'b0; valid = 1'b0;

    chk("done_cnt", done_cnt, 1);
    chk("busy_cnt", busy_cnt, n);
    chk("accepts", acc_cnt, ROW + na);
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("inst[%0d] na=%0d", i, na), 32'(got_q[i]), 32'(exp_q[i]));
    prev_to = exp_to;
  endtask

  task automatic reset_mid();
    start = 1'b1; mode_4b = 1'b1; num_act = CNT_W'(10);
    data_valid = 1'b1; data_in = DW'($urandom); valid = 1'b0;
    for (int k = 1; k <= 2*ROW + COL + 4; k++) begin
      tick();
      start = 1'b0;
      data_in = DW'($urandom);
    end
    chk("pre_rst_exec", 32'(inst), 32'(ins(1, 1, 1, 1, 0)));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_inst", 32'(inst), 0);
    chk("mid_rst_in", 32'(dout), 0);
    chk("mid_rst_ready", 32'(data_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_timeout", 32'(timeout), 0);
    tick();
    reset = 1'b0; exp_in = '0; prev_to = 1'b0;
    tick();
  endtask

  initial begin
    int na_r;
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_inst", 32'(inst), 0);
    chk("rst_in", 32'(dout), 0);
    chk("rst_ready", 32'(data_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    repeat (2) tick();

    run(1'b1, 16, 1'b0, 1'b0, 1'b0);
    run(1'b0, 0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 4, 1'b1, 1'b0, 1'b0);
    run(1'b0, 5, 1'b0, 1'b0, 1'b0);
    run(1'b1, 6, 1'b0, 1'b1, 1'b0);
    run(1'b0, 8, 1'b0, 1'b0, 1'b1);
    run(1'b1, 1, 1'b0, 1'b0, 1'b0);
    reset_mid();
    run(1'b1, 12, 1'b0, 1'b0, 1'b0);
    run(1'b0, 255, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      na_r = $urandom_range(0, 24);
      run(1'($urandom), na_r, 1'b0, 1'($urandom), (na_r >= 6) ? 1'($urandom) : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
